// File: rtl/avr_ram_arbiter.sv
// Arbitrates the single-port data RAM between the CPU (A, priority) and a DMA/loader (B),
// stealing one cycle for B after STARVE_MAX waits. Optional counters: define AVR_ARB_STATS_EN.
module avr_ram_arbiter #(
    parameter int ADDR_BITS  = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          a_addr,
    input  logic                 a_wen,
    input  logic                 a_ren,
    input  logic [7:0]           a_wdata,
    output logic [7:0]           a_rdata,
    output logic                 cpu_hold,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [15:0]          b_addr,
    input  logic [7:0]           b_wdata,
    output logic                 b_ack,
    output logic [7:0]           b_rdata,
    output logic                 b_rvalid,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_wen,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
`ifdef AVR_ARB_STATS_EN
    ,
    output logic [15:0]          stat_b_grants,
    output logic [15:0]          stat_steals
`endif
);

    localparam logic [7:0] HOLD_AT = 8'(STARVE_MAX - 1);

    logic       a_busy;
    logic       b_owner;
    logic [7:0] wait_cnt;

    // B ownership is gated by reset so b_ack drops the instant reset asserts.
    always_comb begin
        a_busy  = (a_wen | a_ren) & ~cpu_hold;
        b_owner = reset_n & b_req & (~a_busy | cpu_hold);
        b_ack   = b_owner;
    end

    // A stolen or withdrawn-hold cycle must never let the CPU's write reach the RAM.
    always_comb begin
        if (b_owner) begin
            ram_addr  = b_addr[ADDR_BITS-1:0];
            ram_wen   = b_we;
            ram_wdata = b_wdata;
        end else begin
            ram_addr  = a_addr[ADDR_BITS-1:0];
            ram_wen   = a_wen & ~cpu_hold;
            ram_wdata = a_wdata;
        end
    end

    assign a_rdata = ram_rdata;
    assign b_rdata = ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
            cpu_hold <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            if (!b_req || b_ack)
                wait_cnt <= 8'd0;
            else if (wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
            cpu_hold <= (wait_cnt == HOLD_AT) & b_req & ~b_ack;
            b_rvalid <= b_ack & ~b_we;
        end
    end

`ifdef AVR_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_b_grants <= 16'd0;
            stat_steals   <= 16'd0;
        end else begin
            if (b_ack)
                stat_b_grants <= stat_b_grants + 16'd1;
            if (cpu_hold)
                stat_steals <= stat_steals + 16'd1;
        end
    end
`endif

    // Upper address bits are deliberately dropped so IO space shadows onto RAM.
    generate
        if (ADDR_BITS < 16) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^{a_addr[15:ADDR_BITS], b_addr[15:ADDR_BITS]};
        end
    endgenerate

endmodule

// File: tb/tb_avr_ram_arbiter.sv
// Directed bench for avr_ram_arbiter with a 4K x 8 synchronous RAM model.
module tb_avr_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] a_addr;
    logic        a_wen;
    logic        a_ren;
    logic [7:0]  a_wdata;
    logic [7:0]  a_rdata;
    logic        cpu_hold;
    logic        b_req;
    logic        b_we;
    logic [15:0] b_addr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;
    logic        b_rvalid;
    logic [11:0] ram_addr;
    logic        ram_wen;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
`ifdef AVR_ARB_STATS_EN
    logic [15:0] stat_b_grants;
    logic [15:0] stat_steals;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];

    avr_ram_arbiter #(.ADDR_BITS(12), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_addr    (a_addr),
        .a_wen     (a_wen),
        .a_ren     (a_ren),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .cpu_hold  (cpu_hold),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .ram_addr  (ram_addr),
        .ram_wen   (ram_wen),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef AVR_ARB_STATS_EN
        ,
        .stat_b_grants (stat_b_grants),
        .stat_steals   (stat_steals)
`endif
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_wen)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic aw, input logic ar, input logic [15:0] aa,
                                  input logic [7:0] ad, input logic br, input logic bw,
                                  input logic [15:0] ba, input logic [7:0] bd);
        a_wen   = aw;
        a_ren   = ar;
        a_addr  = aa;
        a_wdata = ad;
        b_req   = br;
        b_we    = bw;
        b_addr  = ba;
        b_wdata = bd;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        for (int i = 0; i < 4096; i++)
            mem[i] = 8'h00;
        mem[12'h200] = 8'h3C;
        ram_rdata = 8'h00;
        reset_n = 1'b0;
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        #1;
        check_output("reset_cpu_hold", 16'(cpu_hold), 16'h0);
        check_output("reset_b_ack", 16'(b_ack), 16'h0);
        check_output("reset_b_rvalid", 16'(b_rvalid), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] CPU write then read");
        next_cycle();
        apply_stimulus(1, 0, 16'h0123, 8'hA5, 0, 0, 16'h0000, 8'h00);
        check_output("cpu_wr_wen", 16'(ram_wen), 16'h1);
        check_output("cpu_wr_addr", 16'(ram_addr), 16'h0123);
        check_output("cpu_wr_data", 16'(ram_wdata), 16'h00A5);
        check_output("cpu_wr_no_ack", 16'(b_ack), 16'h0);
        next_cycle();
        apply_stimulus(0, 1, 16'h0123, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("cpu_rd_wen", 16'(ram_wen), 16'h0);
        next_cycle();
        apply_stimulus(0, 1, 16'hF123, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("cpu_rdata", 16'(a_rdata), 16'h00A5);
        check_output("alias_addr", 16'(ram_addr), 16'h0123);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("alias_rdata", 16'(a_rdata), 16'h00A5);

        $display("[TB] B read on idle bus");
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0200, 8'h00);
        check_output("b_rd_ack", 16'(b_ack), 16'h1);
        check_output("b_rd_addr", 16'(ram_addr), 16'h0200);
        check_output("b_rd_wen", 16'(ram_wen), 16'h0);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("b_rvalid_set", 16'(b_rvalid), 16'h1);
        check_output("b_rdata", 16'(b_rdata), 16'h003C);
        check_output("b_ack_drop", 16'(b_ack), 16'h0);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("b_rvalid_pulse", 16'(b_rvalid), 16'h0);

        $display("[TB] starvation steal");
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            apply_stimulus(1, 0, 16'h0400 + 16'(i), 8'h10 + 8'(i), 1, 1, 16'h0300, 8'h77);
            if (i < 5) begin
                check_output("starve_no_hold", 16'(cpu_hold), 16'h0);
                check_output("starve_no_ack", 16'(b_ack), 16'h0);
                check_output("starve_cpu_addr", 16'(ram_addr), 16'h0400 + 16'(i));
            end else begin
                check_output("steal_hold", 16'(cpu_hold), 16'h1);
                check_output("steal_ack", 16'(b_ack), 16'h1);
                check_output("steal_addr", 16'(ram_addr), 16'h0300);
                check_output("steal_data", 16'(ram_wdata), 16'h0077);
            end
        end
        next_cycle();
        apply_stimulus(1, 0, 16'h0406, 8'h16, 1, 1, 16'h0301, 8'h55);
        check_output("no_b2b_hold", 16'(cpu_hold), 16'h0);
        check_output("no_b2b_ack", 16'(b_ack), 16'h0);
        check_output("reissue_addr", 16'(ram_addr), 16'h0406);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("after_steal_hold", 16'(cpu_hold), 16'h0);
        check_output("mem_b_write", 16'(mem[12'h300]), 16'h0077);
        check_output("mem_cpu_skipped", 16'(mem[12'h405]), 16'h0000);
        check_output("mem_cpu_before", 16'(mem[12'h404]), 16'h0014);
        check_output("mem_cpu_after", 16'(mem[12'h406]), 16'h0016);
        check_output("mem_b_unacked", 16'(mem[12'h301]), 16'h0000);

        $display("[TB] early withdraw");
        for (int j = 1; j <= 6; j++) begin
            next_cycle();
            apply_stimulus(1, 0, 16'h0450, 8'h01, (j <= 2), 1, 16'h0310, 8'h66);
            check_output("withdraw_no_ack", 16'(b_ack), 16'h0);
            check_output("withdraw_no_hold", 16'(cpu_hold), 16'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            apply_stimulus(1, 0, 16'h0500 + 16'(k), 8'h20 + 8'(k), 1, 1, 16'h0310, 8'h66);
        end
        next_cycle();
        apply_stimulus(1, 0, 16'h0505, 8'h99, 0, 1, 16'h0310, 8'h66);
        check_output("pending_hold", 16'(cpu_hold), 16'h1);
        check_output("pending_no_ack", 16'(b_ack), 16'h0);
        check_output("pending_no_wen", 16'(ram_wen), 16'h0);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("pending_hold_drop", 16'(cpu_hold), 16'h0);
        check_output("pending_mem_cpu", 16'(mem[12'h505]), 16'h0000);
        check_output("pending_mem_b", 16'(mem[12'h310]), 16'h0000);
        check_output("pending_mem_prev", 16'(mem[12'h504]), 16'h0024);

        $display("[TB] async reset mid B read");
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0200, 8'h00);
        check_output("rst_pre_ack", 16'(b_ack), 16'h1);
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0200, 8'h00);
        check_output("rst_pre_rvalid", 16'(b_rvalid), 16'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("rst_rvalid", 16'(b_rvalid), 16'h0);
        check_output("rst_ack", 16'(b_ack), 16'h0);
        check_output("rst_hold", 16'(cpu_hold), 16'h0);
        next_cycle();
        check_output("rst_no_late_rvalid", 16'(b_rvalid), 16'h0);
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        check_output("rst_release_rvalid", 16'(b_rvalid), 16'h0);

        $display("[TB] B writes idle plus one stolen");
        for (int m = 0; m < 3; m++) begin
            next_cycle();
            apply_stimulus(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0600 + 16'(m), 8'h30 + 8'(m));
            check_output("b2b_ack", 16'(b_ack), 16'h1);
        end
        for (int n = 1; n <= 5; n++) begin
            next_cycle();
            apply_stimulus(0, 1, 16'h0000, 8'h00, 1, 1, 16'h0610, 8'h42);
            if (n == 5)
                check_output("stats_steal_ack", 16'(b_ack), 16'h1);
        end
        next_cycle();
        apply_stimulus(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check_output("b2b_mem", 16'(mem[12'h602]), 16'h0032);
        check_output("stolen_mem", 16'(mem[12'h610]), 16'h0042);
`ifdef AVR_ARB_STATS_EN
        check_output("stat_b_grants", stat_b_grants, 16'd4);
        check_output("stat_steals", stat_steals, 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
